int_ctrl: RTL
=============

Name: int_ctrl

Overview:
- Interrupt controller between the interrupt sources and the CPU fetch path. Sources are the timer tick and two external request lines.
- Detects rising edges on the sources, holds them as sticky pending bits, and filters them through a CPU-writable enable mask.
- Dispatches the highest-priority request by steering the PC mux to that source's 10-bit vector and pulsing the return-stack push.
- Blocks further dispatch until the CPU executes a return-from-interrupt.

Parameters:
- PC_W, 10, width of the PC, the vectors and the return-stack entries.
- NSRC, 3, number of interrupt sources. Fixed at 3 for this revision; index 0 has the highest priority.
- MASK_RST, 3'b000, value loaded into the enable mask on reset (all sources disabled).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- src  in  NSRC  request lines: bit0 = timer out_timer, bit1 = ext int1, bit2 = ext int2.
- vec0, vec1, vec2  in  PC_W each  vectors for sources 0..2, supplied by the interruption vector registers.
- mask_we  in  1  write enable for the mask, from the instruction decoder.
- mask_wd  in  NSRC  new mask value.
- reti  in  1  return-from-interrupt executed this cycle; the decoder drives the stack pop in parallel.
- take_int  out  1  select for the PC-next mux; when 1, the PC loads `vector`.
- vector  out  PC_W  dispatch target address.
- push_ret  out  1  one-cycle push strobe to the return stack (the stack captures PC+1).
- in_service  out  1  a handler is active.
- int_id  out  2  index of the source being or last serviced.
- pending  out  NSRC  sticky pending bits, for debug and status reads.
- mask  out  NSRC  current enable mask.

Behaviour:
- Reset, asynchronous:
  - State goes to IDLE.
  - pending=0, src_q=0, mask=MASK_RST, int_id=0.
  - take_int=0, push_ret=0, in_service=0, vector=0.
- Edge detect:
  - src_q registers src every cycle.
  - rise[i] = src[i] & ~src_q[i].
  - On a clock edge where rise[i]=1, pending[i] is set; it is visible the following cycle.
  - A level held high sets pending only once.
- Mask:
  - A write takes effect on the clock edge where mask_we=1.
  - Eligibility uses the registered mask, so a newly written value applies from the next cycle.
  - Masking never clears pending; a masked request waits until it is enabled.
- eligible = pending & mask. Priority is fixed: lowest set index wins.
- FSM:
  - IDLE:
    - If eligible != 0: go to DISPATCH, latch int_id = winner, clear pending[winner].
    - Otherwise stay.
    - reti is ignored.
  - DISPATCH, exactly one cycle:
    - take_int=1, push_ret=1, vector = vec[int_id], selected combinationally from the latched id.
    - Next state is SERVICE.
    - reti is ignored.
  - SERVICE:
    - in_service=1; no nesting, so new edges only accumulate in pending.
    - reti=1 returns to IDLE. A still-eligible request can dispatch on the following edge, so the earliest re-dispatch is 1 cycle after reti.
- Outputs:
  - take_int and push_ret are high only in DISPATCH.
  - in_service is high in DISPATCH and SERVICE.
  - vector=0 whenever take_int=0.
- Simultaneous events:
  - If a rise on the winner arrives in the same cycle its pending bit is cleared at dispatch, the set wins and pending stays 1.
  - A rise and a mask write in the same cycle are both honoured.
- Dispatch latency:
  - Edge sampled at cycle N: pending set at N+1.
  - IDLE→DISPATCH at edge N+1, so take_int is high during cycle N+2.
- Reset mid-DISPATCH or mid-SERVICE: immediate return to the reset state. Pending requests are lost, and the stack is not popped by this block.

Test Plan:
- mask=3'b111, pulse src[1] at cycle 5 with vec1=10'h120 -> take_int and push_ret high for exactly one cycle at cycle 7, vector=10'h120, int_id=1, in_service stays 1 until reti, pending[1]=0.
- Raise src[2] and src[0] in the same cycle, vec0=10'h040 -> first dispatch vector=10'h040, int_id=0; after reti, next dispatch is int_id=2 one cycle later.
- mask=3'b000, pulse src[0] -> pending=3'b001 and no dispatch; write mask=3'b001 -> dispatch 1 cycle after the write edge.
- During SERVICE, pulse src[1] and hold src[2] high for 10 cycles -> no take_int; pending=3'b110 set once each; after reti, dispatch order is 1 then 2.
- Assert reset in SERVICE with pending=3'b100 -> all outputs 0 asynchronously, mask=MASK_RST; after release, no dispatch without a new edge.
- reti pulsed while in IDLE -> no state change, no outputs asserted.

Source files
------------

// File: rtl/int_ctrl.sv
// Interrupt controller: rising-edge capture into sticky pending bits, masked
// fixed-priority selection, one-cycle dispatch pulse and a service lock until reti.
module int_ctrl #(
  parameter int              PC_W     = 10,
  parameter int              NSRC     = 3,
  parameter logic [NSRC-1:0] MASK_RST = 3'b000
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NSRC-1:0] src,
  input  logic [PC_W-1:0] vec0,
  input  logic [PC_W-1:0] vec1,
  input  logic [PC_W-1:0] vec2,
  input  logic            mask_we,
  input  logic [NSRC-1:0] mask_wd,
  input  logic            reti,
  output logic            take_int,
  output logic [PC_W-1:0] vector,
  output logic            push_ret,
  output logic            in_service,
  output logic [1:0]      int_id,
  output logic [NSRC-1:0] pending,
  output logic [NSRC-1:0] mask
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DISPATCH = 2'd1,
    SERVICE  = 2'd2
  } state_t;

  state_t          state_reg, state_next;
  logic [NSRC-1:0] src_q_reg;
  logic [NSRC-1:0] pending_reg, pending_next;
  logic [NSRC-1:0] mask_reg, mask_next;
  logic [1:0]      int_id_reg, int_id_next;

  logic [NSRC-1:0] rise;
  logic [NSRC-1:0] eligible;
  logic [NSRC-1:0] clr;
  logic [1:0]      winner;
  logic            dispatch_go;

  assign eligible    = pending_reg & mask_reg;
  assign dispatch_go = (state_reg == IDLE) && (|eligible);

  // Lowest set index wins; scan from the top so the last hit is the lowest.
  always_comb begin
    winner = 2'd0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (eligible[i]) winner = 2'(i);
    end
  end

  // A rise on the same edge as the dispatch clear re-arms the bit (set wins).
  generate
    for (genvar gi = 0; gi < NSRC; gi++) begin : g_src
      assign rise[gi]         = src[gi] & ~src_q_reg[gi];
      assign clr[gi]          = dispatch_go && (winner == 2'(gi));
      assign pending_next[gi] = (pending_reg[gi] & ~clr[gi]) | rise[gi];
    end
  endgenerate

  assign mask_next   = mask_we ? mask_wd : mask_reg;
  assign int_id_next = dispatch_go ? winner : int_id_reg;

  // State register and datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg   <= IDLE;
      src_q_reg   <= '0;
      pending_reg <= '0;
      mask_reg    <= MASK_RST;
      int_id_reg  <= 2'd0;
    end else begin
      state_reg   <= state_next;
      src_q_reg   <= src;
      pending_reg <= pending_next;
      mask_reg    <= mask_next;
      int_id_reg  <= int_id_next;
    end
  end

  // Next-state logic; reti only matters while a handler is running.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:     if (dispatch_go) state_next = DISPATCH;
      DISPATCH: state_next = SERVICE;
      SERVICE:  if (reti) state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  // Outputs are pure functions of state, so reset clears them immediately.
  always_comb begin
    take_int   = 1'b0;
    push_ret   = 1'b0;
    in_service = 1'b0;
    vector     = '0;
    case (state_reg)
      DISPATCH: begin
        take_int   = 1'b1;
        push_ret   = 1'b1;
        in_service = 1'b1;
        case (int_id_reg)
          2'd0:    vector = vec0;
          2'd1:    vector = vec1;
          default: vector = vec2;
        endcase
      end
      SERVICE:  in_service = 1'b1;
      default: ;
    endcase
  end

  assign int_id  = int_id_reg;
  assign pending = pending_reg;
  assign mask    = mask_reg;

endmodule
